// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard and post-reset clear engine.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_busy,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rd_pend
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [AW-1:0]    ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]    ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [DEPTH-1:0] BIT_ONE   = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  DATA_ZERO = {XLEN{1'b0}};

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [XLEN-1:0]  mem_q [DEPTH];

    logic             wr_hit_s;
    logic             iss_hit_s;
    logic             ready_s;
    logic [DEPTH-1:0] set_mask_s;
    logic [DEPTH-1:0] clr_mask_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_waddr_s;
    logic [XLEN-1:0]  mem_wdata_s;

    assign wr_hit_s   = we && (waddr != ADDR_ZERO);
    assign iss_hit_s  = iss_valid && (iss_addr != ADDR_ZERO);
    assign ready_s    = (state_q == ST_READY) && !rst;
    assign init_busy  = rst || (state_q == ST_CLEAR);
    assign set_mask_s = iss_hit_s ? (BIT_ONE << iss_addr) : {DEPTH{1'b0}};
    assign clr_mask_s = wr_hit_s  ? (BIT_ONE << waddr)    : {DEPTH{1'b0}};

    // Control state, clear counter and scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= ADDR_ZERO;
            pend_q  <= {DEPTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state: walk the clear counter, then track outstanding writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_ONE;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: begin
                // Set is applied after clear so a new producer wins over a retiring one.
                pend_d = (pend_q & ~clr_mask_s) | set_mask_s;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = ADDR_ZERO;
                pend_d  = {DEPTH{1'b0}};
            end
        endcase
        pend_d[0] = 1'b0;
    end

    // Storage write port shared by the clear engine and writeback.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = ADDR_ZERO;
        mem_wdata_s = DATA_ZERO;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_q;
        end else if (wr_hit_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = waddr;
            mem_wdata_s = wdata;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Combinational read ports with pending flags.
    always_comb begin
        logic [AW-1:0] ra;
        ra      = ADDR_ZERO;
        rdata   = {(NRD*XLEN){1'b0}};
        rd_pend = {NRD{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            ra = raddr[k*AW +: AW];
            if (ready_s && (ra != ADDR_ZERO)) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_hit_s && (waddr == ra)) begin
                    rdata[k*XLEN +: XLEN] = wdata;
                    rd_pend[k]            = (iss_hit_s && (iss_addr == ra)) ? pend_q[ra] : 1'b0;
                end else begin
                    rdata[k*XLEN +: XLEN] = mem_q[ra];
                    rd_pend[k]            = pend_q[ra];
                end
`else
                rdata[k*XLEN +: XLEN] = mem_q[ra];
                rd_pend[k]            = pend_q[ra];
`endif
            end else begin
                rdata[k*XLEN +: XLEN] = DATA_ZERO;
                rd_pend[k]            = 1'b0;
            end
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, successor to the single-cycle two-read/one-write file.
- Generalised in data width, depth and read-port count.
- Register 0 is hardwired to zero.
- A per-register pending-write scoreboard supports the pipelined core.
- After reset, a sequential clear engine zeroes the storage array so it can map to RAM without a per-entry reset.
- Sits between decode (read and issue) and writeback (write).

## Interface
- XLEN, 32, data width in bits
- DEPTH, 32, number of registers; power of two, ≥ 2
- AW, 5, address width; equals log2(DEPTH)
- NRD, 2, number of read ports, 1..4
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- init_busy  out  1  high while reset or the clear sequence is active
- we  in  1  writeback write enable
- waddr  in  AW  writeback address
- wdata  in  XLEN  writeback data
- iss_valid  in  1  an instruction with a destination register issues this cycle
- iss_addr  in  AW  destination register of the issuing instruction
- raddr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rdata  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]
- rd_pend  out  NRD  port k's register has an outstanding write

## Operation
- **States:** CLEAR and READY. `rst`=1 forces CLEAR with clear counter `cnt`=0 and all pending bits cleared.
- **CLEAR:**
  - Each clock edge with `rst`=0 writes 0 to entry `cnt`, then increments `cnt`.
  - The edge that writes entry DEPTH-1 moves the block to READY.
  - `we` and `iss_valid` are ignored.
  - All `rdata` lanes read 0 and all `rd_pend` bits read 0.
- **READY writes:** when `we`=1 and `waddr`≠0, `regfile[waddr]` is set to `wdata` at the edge. Writes to address 0 are discarded.
- **Reads:** combinational.
  - `rdata[k]` = `regfile[raddr[k]]`; address 0 always returns 0.
  - Ports are independent and may use the same address.
- **Scoreboard (READY only):**
  - `iss_valid`=1 with `iss_addr`≠0 sets `pend[iss_addr]`.
  - `we`=1 with `waddr`≠0 clears `pend[waddr]`.
  - If set and clear target the same address in one cycle, set wins: a new producer overrides the retiring one.
  - `pend[0]` is constant 0.
- `rd_pend[k]` = `pend[raddr[k]]`; the forwarding adjustment is described under Configuration.
- **Reset mid-clear:** restarts at `cnt`=0. **Reset in READY:** discards in-flight writes and issues in that cycle.

## Timing
- **Reset values:**
  - `init_busy`=1.
  - `rdata`=0 on all lanes.
  - `rd_pend`=0 on all bits.
  - `pend`=0 and `cnt`=0.
- **Clear latency:** `init_busy` stays 1 while `rst`=1, then falls after the DEPTH-th rising edge with `rst`=0. With DEPTH=32, that is the 32nd edge after release.
- **Write-to-read:** a read of the written address sees the new value from the cycle after the write edge. Same-cycle visibility depends on Configuration.
- **Issue-to-pending:** `rd_pend` rises the cycle after `iss_valid`.
- **Single write port:** at most one write per cycle; no write-port arbitration.

## Configuration
- **Macro:** `REGFILE_BYPASS_EN`, controlling write-through forwarding.
- **Defined (READY only):**
  - For any port k with `we`=1, `waddr`≠0 and `waddr`==`raddr[k]`, `rdata[k]`=`wdata` in the same cycle.
  - In that case `rd_pend[k]`=0, unless `iss_valid` targets the same address in that cycle.
  - Forwarding applies per port, independently.
- **Not defined:**
  - No forwarding: `rdata` shows the stored value until the write edge.
  - `rd_pend` shows only registered state.
  - Decode must stall one cycle on a writeback/read collision.

## Test plan
- **Clear sequence:**
  - Stimulus: hold `rst`=1 for 3 cycles, then release.
  - Required: `init_busy` falls exactly 32 edges later; reading every address 0..31 afterwards returns 0x00000000.
- **Basic write/read:**
  - Stimulus: write 0xDEADBEEF to x5 and 0x12345678 to x0; read x5 on port 0 and x0 on port 1 the next cycle.
  - Required: 0xDEADBEEF and 0x00000000.
- **Scoreboard:**
  - Stimulus: issue x7; next cycle read x7; then write x7 with 0xA5A5A5A5 while `iss_valid` also targets x7 in the same cycle.
  - Required: `rd_pend`=1 the cycle after issue, and `rd_pend` stays 1 after the collision because set wins.
- **Forwarding:**
  - Stimulus: write 0xCAFEF00D to x3 while ports 0 and 1 both read x3.
  - Required: with `REGFILE_BYPASS_EN`, both lanes show 0xCAFEF00D in that same cycle; without it, both show the old value, then 0xCAFEF00D the next cycle.
- **Reset mid-clear and mid-operation:**
  - Stimulus: assert `rst` at `cnt`=10 and re-release.
  - Required: `init_busy` falls 32 edges after the second release.
  - Stimulus: assert `rst` in READY with `we`=1.
  - Required: that write is dropped and all `rd_pend`=0.
